// File: rtl/phy_tx_pkg.sv
// phy_tx_pkg: shared constants and helpers for the multilane PHY
// transmit path (default idle symbol, width and index math).
package phy_tx_pkg;

  localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ring_idx(
    input int base,
    input int k,
    input int n
  );
    return (base + k) % n;
  endfunction

  function automatic int slice_lsb(
    input int idx,
    input int width
  );
    return idx * width;
  endfunction

endpackage

// File: rtl/phy_tx_lane_ser.sv
// phy_tx_lane_ser: one lane's MSB-first serialiser; loads a word or
// idle symbol on the load strobe and shifts one bit per enabled cycle.
module phy_tx_lane_ser
  import phy_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             is_data,
  output logic             ser_out,
  output logic             lane_vld
);

  logic [WIDTH-1:0] sh;

  // The MSB goes straight to ser_out; sh keeps the remaining bits.
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      sh       <= '0;
      ser_out  <= 1'b0;
      lane_vld <= 1'b0;
    end else if (enable) begin
      if (load) begin
        ser_out  <= word[WIDTH-1];
        sh       <= word << 1;
        lane_vld <= is_data;
      end else begin
        ser_out <= sh[WIDTH-1];
        sh      <= sh << 1;
      end
    end
  end

endmodule

// File: rtl/phy_tx_multilane.sv
// phy_tx_multilane: round-robin arbiter, word FIFO and lane striping.
// Define PHY_TX_IDLE_COMMA_EN to send IDLE_SYM on idle lanes.
module phy_tx_multilane
  import phy_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 2,
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(IDLE_SYM_DEF)
) (
  input  logic                    clk_8f,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_IN-1:0]       valid_in,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic [NUM_IN-1:0]       ready_out,
  output logic [NUM_LANES-1:0]    ser_out,
  output logic [NUM_LANES-1:0]    lane_vld,
  output logic                    sym_strb
);

  localparam int PW = clog2(NUM_IN);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam int BW = clog2(WIDTH);

`ifdef PHY_TX_IDLE_COMMA_EN
  localparam logic [WIDTH-1:0] IDLE_WORD = IDLE_SYM;
`else
  localparam logic [WIDTH-1:0] IDLE_WORD = IDLE_SYM & '0;
`endif

  logic [BW-1:0]    bit_cnt;
  logic             load;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    n_pop;
  logic             can_wr;
  logic             wr;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] ch_word [NUM_IN];
  logic [WIDTH-1:0] mem [DEPTH];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    assign ch_word[i] = data_in[slice_lsb(i, WIDTH) +: WIDTH];
  end

  assign load = enable & (bit_cnt == BW'(WIDTH - 1));
  assign can_wr = reset & enable & (count < CW'(DEPTH));
  assign wr = |ready_out;

  // First valid channel at or after rr_ptr wins.
  always_comb begin
    logic [PW-1:0] c;
    logic          found;
    c         = '0;
    found     = 1'b0;
    ready_out = '0;
    gnt       = '0;
    wr_word   = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      c = PW'(ring_idx(int'(rr_ptr), j, NUM_IN));
      if (can_wr && !found && valid_in[c]) begin
        found        = 1'b1;
        ready_out[c] = 1'b1;
        gnt          = c;
        wr_word      = ch_word[c];
      end
    end
  end

  always_comb begin
    n_pop = '0;
    if (load) begin
      n_pop = (count < CW'(NUM_LANES)) ? count : CW'(NUM_LANES);
    end
  end

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      bit_cnt  <= '0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sym_strb <= 1'b0;
    end else if (enable) begin
      bit_cnt  <= load ? '0 : bit_cnt + 1'b1;
      sym_strb <= load;
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt == PW'(NUM_IN - 1)) ? '0 : gnt + 1'b1;
      end
      rd_ptr <= rd_ptr + AW'(n_pop);
      count  <= count + CW'(wr) - n_pop;
    end
  end

  always_ff @(posedge clk_8f) begin
    if (wr) mem[wr_ptr] <= wr_word;
  end

  // Lane k takes the k-th oldest word, or idle when fewer are queued.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [AW-1:0]    idx;
    logic             is_data;
    logic [WIDTH-1:0] word;

    assign idx     = rd_ptr + AW'(k);
    assign is_data = count > CW'(k);
    assign word    = is_data ? mem[idx] : IDLE_WORD;

    phy_tx_lane_ser #(
      .WIDTH(WIDTH)
    ) u_ser (
      .clk_8f  (clk_8f),
      .reset   (reset),
      .enable  (enable),
      .load    (load),
      .word    (word),
      .is_data (is_data),
      .ser_out (ser_out[k]),
      .lane_vld(lane_vld[k])
    );
  end

endmodule
